divide: RTL and testbench

DIVIDE -- requirements
Module: divide

---
 rtl/divide.sv | 100 ++++++++++
 tb/tb_divide.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/divide.sv
// divide: 32-bit signed sequential divider with 32-step restoring core, p = {remainder, quotient}
//   ports: clock, clear (async active-high), start, x (dividend), y (divisor),
//          p[63:32] remainder / p[31:0] quotient, busy, done (1-cycle pulse), dz (divide-by-zero)
module divide (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] p,
  output logic        busy,
  output logic        done,
  output logic        dz
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [32:0] r_q, r_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0] cnt_q, cnt_d;
  logic qs_q, qs_d, rs_q, rs_d, dz_q, dz_d;
  logic [63:0] p_q, p_d;
  logic accept, y_zero;
  logic [31:0] ax, ay, q_fix, r_fix;
  logic [32:0] sh, diff;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      r_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      qs_q <= 1'b0;
      rs_q <= 1'b0;
      p_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      qs_q <= qs_d;
      rs_q <= rs_d;
      p_q <= p_d;
      dz_q <= dz_d;
    end
  end
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign y_zero = (y == 32'd0);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = !start ? IDLE : (y_zero ? DONE : CALC);
      CALC:       state_d = (cnt_q == 5'd31) ? FIX : CALC;
      default:    state_d = DONE;
    endcase
  end
  // magnitudes stay unsigned so 0x80000000 survives negation
  assign ax = x[31] ? -x : x;
  assign ay = y[31] ? -y : y;
  // a_q holds the dividend bits still to be shifted in and collects quotient bits from the right
  assign sh = {r_q[31:0], a_q[31]};
  assign diff = sh - {1'b0, b_q};
  assign q_fix = qs_q ? -a_q : a_q;
  assign r_fix = rs_q ? -r_q[31:0] : r_q[31:0];
  always_comb begin
    r_d = r_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    qs_d = qs_q;
    rs_d = rs_q;
    p_d = p_q;
    dz_d = dz_q;
    if (accept && y_zero) begin
      p_d = {x, 32'hFFFF_FFFF};
      dz_d = 1'b1;
    end else if (accept) begin
      r_d = '0;
      a_d = ax;
      b_d = ay;
      cnt_d = '0;
      qs_d = x[31] ^ y[31];
      rs_d = x[31];
    end else if (state_q == CALC) begin
      r_d = diff[32] ? sh : diff;
      a_d = {a_q[30:0], ~diff[32]};
      cnt_d = cnt_q + 5'd1;
    end else if (state_q == FIX) begin
      p_d = {r_fix, q_fix};
      dz_d = 1'b0;
    end
  end
  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
    p = p_q;
    dz = dz_q;
  end
endmodule

// File: tb/tb_divide.sv
// tb_divide: randomized self-checking bench for divide against a plain-arithmetic reference
module tb_divide;
  logic clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic [63:0] p;
  logic busy, done, dz;
  int ntot = 0, npass = 0;
  divide dut (.clock(clock), .clear(clear), .start(start), .x(x), .y(y),
              .p(p), .busy(busy), .done(done), .dz(dz));
  always #5 clock = ~clock;
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    x = a;
    y = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
  endtask
  task automatic wait_done(input int n0, output int n, output int bb);
    n = n0;
    bb = 0;
    while (!done && n < 100) begin
      if (!busy) bb++;
      @(posedge clock);
      #1;
      n++;
    end
  endtask
  task automatic test_reset;
    #12;
    ntot++; if (p !== 64'd0 || dz !== 1'b0) $display("FAIL reset_p_dz p=%h dz=%b want 0", p, dz); else npass++;
    ntot++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done busy=%b done=%b want 0", busy, done); else npass++;
    @(negedge clock);
    clear = 1'b0;
  endtask
  task automatic test_vectors;
    logic [31:0] vx [6] = '{32'd100, -32'd100, 32'd100, -32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vy [6] = '{32'd7, 32'd7, -32'd7, -32'd7, 32'hFFFF_FFFF, 32'd1};
    logic [63:0] vp [6] = '{64'h00000002_0000000E, 64'hFFFFFFFE_FFFFFFF2, 64'h00000002_FFFFFFF2,
                            64'hFFFFFFFE_0000000E, 64'h00000000_80000000, 64'h00000000_80000000};
    int n, bb;
    for (int i = 0; i < 6; i++) begin
      launch(vx[i], vy[i]);
      wait_done(1, n, bb);
      ntot++; if (n !== 34 || bb !== 0) $display("FAIL vec%0d_timing done_edge=%0d busy_gaps=%0d want 34/0", i, n, bb); else npass++;
      ntot++; if (p !== vp[i] || dz !== 1'b0) $display("FAIL vec%0d_result p=%h dz=%b want %h/0", i, p, dz, vp[i]); else npass++;
      @(posedge clock);
      #1;
      ntot++; if (done !== 1'b0) $display("FAIL vec%0d_done_pulse done=%b want 0", i, done); else npass++;
    end
  endtask
  task automatic test_div_zero;
    int n, bb;
    launch(32'd5, 32'd0);
    wait_done(1, n, bb);
    ntot++; if (n !== 1) $display("FAIL dz_timing done_edge=%0d want 1", n); else npass++;
    ntot++; if (p !== 64'h00000005_FFFFFFFF || dz !== 1'b1) $display("FAIL dz_result p=%h dz=%b want 00000005ffffffff/1", p, dz); else npass++;
    @(posedge clock);
    #1;
    ntot++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL dz_pulse done=%b busy=%b want 0/0", done, busy); else npass++;
    launch(32'd100, 32'd7);
    ntot++; if (dz !== 1'b1 || p !== 64'h00000005_FFFFFFFF) $display("FAIL dz_hold p=%h dz=%b want old result", p, dz); else npass++;
    wait_done(1, n, bb);
    ntot++; if (p !== 64'h00000002_0000000E || dz !== 1'b0) $display("FAIL dz_recover p=%h dz=%b want 000000020000000e/0", p, dz); else npass++;
  endtask
  task automatic test_ignore_start;
    int n, bb;
    launch(32'd100, 32'd7);
    repeat (8) @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    x = 32'd9;
    y = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(10, n, bb);
    ntot++; if (n !== 34 || bb !== 0) $display("FAIL ignore_timing done_edge=%0d busy_gaps=%0d want 34/0", n, bb); else npass++;
    ntot++; if (p !== 64'h00000002_0000000E) $display("FAIL ignore_result p=%h want 000000020000000e", p); else npass++;
  endtask
  task automatic test_clear_mid;
    int n, bb, seen;
    launch(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    ntot++; if (p !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0)
      $display("FAIL clear_async p=%h busy=%b done=%b dz=%b want all 0", p, busy, done, dz); else npass++;
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) seen++;
    end
    ntot++; if (seen !== 0) $display("FAIL clear_no_done active_cycles=%0d want 0", seen); else npass++;
    launch(32'd7, 32'd2);
    wait_done(1, n, bb);
    ntot++; if (n !== 34 || p !== 64'h00000001_00000003) $display("FAIL clear_restart done_edge=%0d p=%h want 34/0000000100000003", n, p); else npass++;
  endtask
  task automatic test_back_to_back;
    int n, bb;
    launch(-32'd1000, 32'd33);
    wait_done(1, n, bb);
    launch(32'd77, -32'd5);
    ntot++; if (busy !== 1'b1 || done !== 1'b0 || p !== model(-32'd1000, 32'd33))
      $display("FAIL b2b_accept busy=%b done=%b p=%h want 1/0/%h", busy, done, p, model(-32'd1000, 32'd33)); else npass++;
    wait_done(1, n, bb);
    ntot++; if (n !== 34 || p !== model(32'd77, -32'd5)) $display("FAIL b2b_result done_edge=%0d p=%h want 34/%h", n, p, model(32'd77, -32'd5)); else npass++;
  endtask
  task automatic test_random;
    logic [31:0] a, b;
    logic [63:0] prev_p;
    logic prev_dz;
    int n, bb, sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 20)) : (sel < 5) ? -32'($urandom_range(1, 20)) : $urandom;
      if (sel == 7) a = 32'h8000_0000;
      prev_p = p;
      prev_dz = dz;
      launch(a, b);
      if (b != 32'd0) begin
        ntot++; if (p !== prev_p || dz !== prev_dz) $display("FAIL rnd%0d_hold p=%h dz=%b want %h/%b", i, p, dz, prev_p, prev_dz); else npass++;
      end
      wait_done(1, n, bb);
      ntot++; if (n !== (b == 32'd0 ? 1 : 34) || bb !== 0)
        $display("FAIL rnd%0d_timing x=%h y=%h done_edge=%0d busy_gaps=%0d", i, a, b, n, bb); else npass++;
      ntot++; if (p !== model(a, b) || dz !== (b == 32'd0))
        $display("FAIL rnd%0d_result x=%h y=%h p=%h dz=%b want %h/%b", i, a, b, p, dz, model(a, b), b == 32'd0); else npass++;
    end
  endtask
  initial begin
    test_reset;
    test_vectors;
    test_div_zero;
    test_ignore_start;
    test_clear_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
